// File: rtl/io_char_sched_if.sv
// Character-source handshakes, word-timing strobes and OA insert outputs of the
// slow-in character scheduler.
interface io_char_sched_if;
    logic       T0;
    logic       T29;
    logic       IN;
    logic       TYP_VALID;
    logic [4:0] TYP_CODE;
    logic       TYP_READY;
    logic       PR_VALID;
    logic [4:0] PR_CODE;
    logic       PR_READY;
    logic       OA1;
    logic       OA2;
    logic       OA3;
    logic       OA4;
    logic       OF_CTL;
    logic       CHAR_WORD;
    logic       CHAR_DONE;
    logic       SRC;
    logic       BUSY;

    modport master (
        output T0, T29, IN, TYP_VALID, TYP_CODE, PR_VALID, PR_CODE,
        input  TYP_READY, PR_READY, OA1, OA2, OA3, OA4, OF_CTL,
               CHAR_WORD, CHAR_DONE, SRC, BUSY
    );

    modport slave (
        input  T0, T29, IN, TYP_VALID, TYP_CODE, PR_VALID, PR_CODE,
        output TYP_READY, PR_READY, OA1, OA2, OA3, OA4, OF_CTL,
               CHAR_WORD, CHAR_DONE, SRC, BUSY
    );
endinterface

// File: rtl/io_char_sched.sv
// Slow-in character scheduler: arbitrates TYP/PR, presents one character for a
// single drum word, then holds off for GAP_WORDS word times.
module io_char_sched #(
    parameter int unsigned GAP_WORDS = 4,
    parameter bit          PR_PRIO   = 1'b0
) (
    input logic            CLOCK,
    input logic            rst,
    io_char_sched_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StArm, StPresent, StGap} state_e;

    localparam logic [3:0] GapLoad = 4'(GAP_WORDS);

    state_e     state;
    logic [3:0] gap_cnt;
    logic       last;       // last granted source, 1 = PR
    logic [4:0] code;
    logic       src;
    logic       grant_pr;
    logic       grant_typ;
    logic       take_pr;
    logic       take_typ;
    logic       char_word;

    always_comb begin
        grant_pr  = bus.PR_VALID & (PR_PRIO | ~bus.TYP_VALID | ~last);
        grant_typ = bus.TYP_VALID & ~grant_pr;
        take_pr   = (state == StIdle) & bus.IN & grant_pr & ~rst;
        take_typ  = (state == StIdle) & bus.IN & grant_typ & ~rst;
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state   <= StIdle;
            gap_cnt <= 4'd0;
            last    <= 1'b1;
            code    <= 5'd0;
            src     <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (take_pr | take_typ) begin
                        code  <= take_pr ? bus.PR_CODE : bus.TYP_CODE;
                        src   <= take_pr;
                        last  <= take_pr;
                        state <= StArm;
                    end
                end
                StArm: begin
                    // With IN low the character simply waits here for a later T0.
                    if (bus.T0 && bus.IN) state <= StPresent;
                end
                StPresent: begin
                    // T0 is ignored here, so a turn-on T0/T29 overlap still ends the word.
                    if (bus.T29) begin
                        if (GapLoad == 4'd0) begin
                            state <= StIdle;
                        end else begin
                            state   <= StGap;
                            gap_cnt <= GapLoad;
                        end
                    end
                end
                StGap: begin
                    if (bus.T0) begin
                        gap_cnt <= gap_cnt - 4'd1;
                        if (gap_cnt == 4'd1) state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign char_word     = (state == StPresent) & ~rst;
    assign bus.TYP_READY = take_typ;
    assign bus.PR_READY  = take_pr;
    assign bus.OA1       = char_word & code[0];
    assign bus.OA2       = char_word & code[1];
    assign bus.OA3       = char_word & code[2];
    assign bus.OA4       = char_word & code[3];
    assign bus.OF_CTL    = char_word & code[4];
    assign bus.CHAR_WORD = char_word;
    assign bus.CHAR_DONE = char_word & bus.T29;
    assign bus.SRC       = src & ~rst;
    assign bus.BUSY      = (state != StIdle) & ~rst;
endmodule
